// File: rtl/mole_game_if.sv
// rtl/mole_game_if.sv - board/ring-counter side signals of the whack-a-mole game sequencer
interface mole_game_if #(
  parameter int NUM_POS = 10,
  parameter int SCORE_W = 8
);
  logic               start_btn;
  logic [NUM_POS-1:0] hit_btn;
  logic [NUM_POS-1:0] mole_posit;
  logic               ring_en;
  logic               ring_reset;
  logic [SCORE_W-1:0] score;
  logic [2:0]         lives;
  logic               led_flash;
  logic               game_over;
  logic               game_won;

  modport master (
    input  start_btn, hit_btn, mole_posit,
    output ring_en, ring_reset, score, lives, led_flash, game_over, game_won
  );

  modport slave (
    output start_btn, hit_btn, mole_posit,
    input  ring_en, ring_reset, score, lives, led_flash, game_over, game_won
  );
endinterface

// File: rtl/mole_game_ctrl.sv
// rtl/mole_game_ctrl.sv - whack-a-mole game sequencer: ring counter control, hit judging, score and lives
module mole_game_ctrl #(
  parameter int NUM_POS      = 10,
  parameter int TICK_DIV     = 4,
  parameter int FREEZE_TICKS = 2,
  parameter int MAX_LIVES    = 3,
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 8
) (
  input  logic       clk,
  input  logic       game_reset_n,
  mole_game_if.master bus
);
  localparam int HOLD = FREEZE_TICKS * TICK_DIV;
  localparam int TW   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [TW-1:0]      TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0]      HOLD_LAST  = TW'(HOLD - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);
  localparam logic [2:0]         LIVES_INIT = 3'(MAX_LIVES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_HIT  = 3'd3,
    S_MISS = 3'd4,
    S_OVER = 3'd5,
    S_WIN  = 3'd6
  } state_t;

  state_t             state_q, state_next;
  logic [TW-1:0]      tick_q, tick_next;
  logic               start_d;
  logic [NUM_POS-1:0] hit_d;
  logic [SCORE_W-1:0] score_q, score_next, score_inc;
  logic [2:0]         lives_q, lives_next;
  logic               ring_en_q, ring_en_next;
  logic               ring_reset_q, led_flash_q, game_over_q, game_won_q;
  logic               start_rise, hit_rise, hit_ok;

  assign start_rise = bus.start_btn & ~start_d;
  assign hit_rise   = (|bus.hit_btn) & ~(|hit_d);
  // A correct hit needs exactly one button matching a well-formed one-hot mole.
  assign hit_ok     = (bus.hit_btn == bus.mole_posit) && $onehot(bus.mole_posit);
  assign score_inc  = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);

  always_ff @(posedge clk) begin
    if (!game_reset_n) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      start_d      <= 1'b0;
      hit_d        <= '0;
      score_q      <= '0;
      lives_q      <= LIVES_INIT;
      ring_en_q    <= 1'b0;
      ring_reset_q <= 1'b1;
      led_flash_q  <= 1'b0;
      game_over_q  <= 1'b0;
      game_won_q   <= 1'b0;
    end else begin
      state_q      <= state_next;
      tick_q       <= tick_next;
      start_d      <= bus.start_btn;
      hit_d        <= bus.hit_btn;
      score_q      <= score_next;
      lives_q      <= lives_next;
      ring_en_q    <= ring_en_next;
      ring_reset_q <= (state_next == S_IDLE) || (state_next == S_LOAD);
      led_flash_q  <= (state_next == S_HIT);
      game_over_q  <= (state_next == S_OVER);
      game_won_q   <= (state_next == S_WIN);
    end
  end

  always_comb begin
    state_next   = state_q;
    tick_next    = tick_q;
    score_next   = score_q;
    lives_next   = lives_q;
    ring_en_next = 1'b0;
    case (state_q)
      S_IDLE: if (start_rise) state_next = S_LOAD;
      S_LOAD: begin
        state_next = S_RUN;
        tick_next  = '0;
      end
      S_RUN: begin
        if (tick_q == TICK_LAST) begin
          tick_next    = '0;
          ring_en_next = 1'b1;
        end else begin
          tick_next = tick_q + TW'(1);
        end
        if (hit_rise) begin
          if (hit_ok) begin
            score_next   = score_inc;
            tick_next    = '0;
            ring_en_next = 1'b0;
            state_next   = (score_inc == SCORE_WIN) ? S_WIN : S_HIT;
          end else begin
            state_next = S_MISS;
          end
        end
      end
      S_HIT: begin
        if (tick_q == HOLD_LAST) begin
          tick_next  = '0;
          state_next = S_RUN;
        end else begin
          tick_next = tick_q + TW'(1);
        end
      end
      S_MISS: begin
        lives_next = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
        state_next = (lives_q <= 3'd1) ? S_OVER : S_RUN;
      end
      S_OVER, S_WIN: if (start_rise) state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
    if (state_next == S_LOAD) begin
      score_next = '0;
      lives_next = LIVES_INIT;
      tick_next  = '0;
    end
  end

  assign bus.ring_en    = ring_en_q;
  assign bus.ring_reset = ring_reset_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.led_flash  = led_flash_q;
  assign bus.game_over  = game_over_q;
  assign bus.game_won   = game_won_q;
endmodule
